// File: rtl/hilo_md_unit.sv
// hilo_md_unit: multi-cycle mult/div unit owning the HI/LO register pair.
module hilo_md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]   r_op;
    logic [31:0]  r_a, r_b, r_hi, r_lo;
    logic         w_accept, w_long, w_done, w_bz, w_ovf, w_wr;
    logic [31:0]  w_bs, w_bu, w_q_s, w_r_s, w_q_u, w_r_u;
    logic [63:0]  w_prod_s, w_prod_u, w_res;

    assign busy     = (r_state == RUN);
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign w_accept = start && !req && !busy && md_op != 3'd0 && md_op != 3'd7;
    assign w_long   = w_accept && md_op <= 3'd4;
    assign w_done   = busy && r_cnt == CW'(1);

    // Substituting a divisor of 1 covers both x/0 (result discarded) and INT_MIN/-1 (quotient = dividend, remainder 0).
    assign w_bz     = (r_b == 32'd0);
    assign w_ovf    = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    assign w_bs     = (w_bz || w_ovf) ? 32'd1 : r_b;
    assign w_bu     = w_bz ? 32'd1 : r_b;
    assign w_q_s    = $signed(r_a) / $signed(w_bs);
    assign w_r_s    = $signed(r_a) % $signed(w_bs);
    assign w_q_u    = r_a / w_bu;
    assign w_r_u    = r_a % w_bu;
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_res    = (r_op == 3'd1) ? w_prod_s :
                      (r_op == 3'd2) ? w_prod_u :
                      (r_op == 3'd3) ? {w_r_s, w_q_s} : {w_r_u, w_q_u};
    assign w_wr     = !(r_op >= 3'd3 && w_bz);

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (w_long ? RUN : IDLE) : (w_done ? IDLE : RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= 3'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            if (w_long) begin
                r_a   <= A;
                r_b   <= B;
                r_op  <= md_op;
                r_cnt <= (md_op <= 3'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (busy) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_done && w_wr) {r_hi, r_lo} <= w_res;
            if (w_accept && md_op == 3'd5) r_hi <= A;
            if (w_accept && md_op == 3'd6) r_lo <= A;
        end
    end
endmodule

// File: tb/tb_hilo_md_unit.sv
// tb_hilo_md_unit: table-driven scoreboard bench for hilo_md_unit.
module tb_hilo_md_unit;
    logic        clk = 1'b0;
    logic        reset, start, req, busy;
    logic [2:0]  md_op;
    logic [31:0] A, B, HI, LO;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          n;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
    } exp_t;

    vec_t tv[12];
    exp_t sb[$];

    hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .req(req), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge; consecutive calls therefore issue back-to-back ops.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic rq, input int n, input logic [31:0] eh,
                          input logic [31:0] el, input string tag);
        exp_t e;
        int   cnt;
        chk({tag, " busy@start"}, {31'd0, busy}, 32'd0);
        start = 1'b1; md_op = op; A = a; B = b; req = rq;
        sb.push_back('{hi: eh, lo: el});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; req = 1'b0; A = ~a; B = ~b;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, cnt, n);
        e = sb.pop_front();
        chk({tag, " HI"}, HI, e.hi);
        chk({tag, " LO"}, LO, e.lo);
    endtask

    initial begin
        int cnt;
        exp_t e;
        tv[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        tv[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
        tv[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        tv[3]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        tv[4]  = '{3'd4, 32'd100,       32'd7,        32'd2,         32'd14,        10};
        tv[5]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        tv[6]  = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        tv[7]  = '{3'd4, 32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, 10};
        tv[8]  = '{3'd5, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'h0FFF_FFFF, 0};
        tv[9]  = '{3'd6, 32'hCAFE_F00D, 32'd0,        32'h1234_5678, 32'hCAFE_F00D, 0};
        tv[10] = '{3'd4, 32'd5,         32'd0,        32'h1234_5678, 32'hCAFE_F00D, 10};
        tv[11] = '{3'd3, 32'hFFFF_FFFB, 32'd0,        32'h1234_5678, 32'hCAFE_F00D, 10};

        reset = 1'b1; start = 1'b0; req = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);

        for (int i = 0; i < 12; i++)
            run_op(tv[i].op, tv[i].a, tv[i].b, 1'b0, tv[i].n, tv[i].hi, tv[i].lo, $sformatf("vec%0d", i));

        run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1, 0, 32'h1234_5678, 32'hCAFE_F00D, "mthi_req");
        run_op(3'd7, 32'h1, 32'h1, 1'b0, 0, 32'h1234_5678, 32'hCAFE_F00D, "op7");
        run_op(3'd0, 32'h1, 32'h1, 1'b0, 0, 32'h1234_5678, 32'hCAFE_F00D, "op0");

        // Start during busy is ignored; operand changes and req while running have no effect.
        start = 1'b1; md_op = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3;
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            start = (cnt == 2);
            md_op = (cnt == 2) ? 3'd5 : 3'd1;
            A = 32'h5 + cnt; B = 32'h7 * cnt;
            req = (cnt == 3);
            @(negedge clk);
        end
        start = 1'b0; req = 1'b0;
        chk("overlap busy_cycles", cnt, 5);
        e = sb.pop_front();
        chk("overlap HI", HI, e.hi);
        chk("overlap LO", LO, e.lo);
        repeat (3) @(negedge clk);
        chk("overlap no_restart", {31'd0, busy}, 32'd0);
        chk("overlap HI hold", HI, 32'hFFFF_FFFF);

        // Reset in the third busy cycle of a divide, colliding with an mthi start.
        start = 1'b1; md_op = 3'd4; A = 32'd100; B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst pre busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; start = 1'b1; md_op = 3'd5; A = 32'hFFFF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst HI", HI, 32'd0);
        chk("rst LO", LO, 32'd0);
        repeat (15) @(negedge clk);
        chk("rst late busy", {31'd0, busy}, 32'd0);
        chk("rst late HI", HI, 32'd0);
        chk("rst late LO", LO, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
